video_dec: RTL and testbench

Video-timing-to-stream decoder, the receive-side counterpart of the stream-to-timing encoder feeding `dvi_tx`. It accepts a parallel DE/VSYNC/pixel bus, for example from a DVI/TMDS receiver, in the pixel clock domain. It re-frames that bus into an AXI4-Stream with start-of-frame (tuser) and end-of-line (tlast) markers, and buffers it in a small FIFO to absorb downstream back-pressure. It also measures active resolution and reports lock.

---
 rtl/video_dec.sv | 177 +++++++++++++++++
 tb/tb_video_dec.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dec.sv
`default_nettype none
// =============================================================================
// Module   : video_dec
// Purpose  : Re-frames a DE/VSYNC/pixel bus into an AXI4-Stream (tuser = SOF,
//            tlast = EOL) through a FWFT FIFO. Resolution/lock measurement is
//            built only when VIDEO_DEC_MEASURE_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module video_dec #(
   parameter int BITS_PER_PIXEL = 24,
   parameter int FIFO_DEPTH     = 16,
   parameter int CNT_W          = 12
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      de_i,
   input  logic                      vsync_i,
   input  logic [BITS_PER_PIXEL-1:0] pixel_i,
   output logic                      out_axis_tvalid,
   input  logic                      out_axis_tready,
   output logic [BITS_PER_PIXEL-1:0] out_axis_tdata,
   output logic                      out_axis_tuser,
   output logic                      out_axis_tlast,
   output logic                      overflow_o,
   output logic [CNT_W-1:0]          h_active_o,
   output logic [CNT_W-1:0]          v_active_o,
   output logic                      locked_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = BITS_PER_PIXEL + 2;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      ACTIVE  = 2'd1,
      DROP    = 2'd2
   } state_t;

   logic                      de_q, vs_q, vs_prev_q;
   logic [BITS_PER_PIXEL-1:0] pix_q;
   state_t                    state_q, state_d;
   logic                      sof_q, sof_d, ovf_q, ovf_d;
   logic                      pend_v_q, pend_v_d, pend_sof_q, pend_sof_d;
   logic [BITS_PER_PIXEL-1:0] pend_pix_q, pend_pix_d;
   logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]               count_q, count_d;
   logic [EW-1:0]             mem_q [FIFO_DEPTH];
   logic                      vs_edge, pop, full, push_ok, ovf_ev, accept, w_sof, w_last;

   always_comb begin
      vs_edge = vs_q & ~vs_prev_q;
      pop     = (count_q != '0) & out_axis_tready;
      full    = (count_q == (AW+1)'(FIFO_DEPTH));
      // The pending pixel always drains the cycle after it was loaded.
      push_ok = pend_v_q & (~full | pop);
      ovf_ev  = pend_v_q & ~push_ok;
      w_last  = ~de_q | vs_edge;
      accept  = de_q & ~ovf_ev & ((state_q == ACTIVE) | vs_edge);
      w_sof   = vs_edge | sof_q;

      state_d = state_q;
      case (state_q)
         ACTIVE:  if (ovf_ev) state_d = DROP;
         default: if (vs_edge) state_d = ACTIVE;
      endcase

      pend_v_d   = accept;
      pend_pix_d = accept ? pix_q : pend_pix_q;
      pend_sof_d = accept ? w_sof : pend_sof_q;
      sof_d      = accept ? 1'b0 : w_sof;
      ovf_d      = ovf_q | ovf_ev;

      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         de_q       <= 1'b0;
         vs_q       <= 1'b0;
         vs_prev_q  <= 1'b0;
         pix_q      <= '0;
         state_q    <= WAIT_VS;
         sof_q      <= 1'b0;
         ovf_q      <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_sof_q <= 1'b0;
         pend_pix_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         de_q       <= de_i;
         vs_q       <= vsync_i;
         vs_prev_q  <= vs_q;
         pix_q      <= pixel_i;
         state_q    <= state_d;
         sof_q      <= sof_d;
         ovf_q      <= ovf_d;
         pend_v_q   <= pend_v_d;
         pend_sof_q <= pend_sof_d;
         pend_pix_q <= pend_pix_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= {pend_sof_q, w_last, pend_pix_q};
   end

   assign out_axis_tvalid = (count_q != '0);
   assign {out_axis_tuser, out_axis_tlast, out_axis_tdata} = mem_q[rd_ptr_q];
   assign overflow_o = ovf_q;

`ifdef VIDEO_DEC_MEASURE_EN
   logic             de_prev_q;
   logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, line_len_q, line_len_d;
   logic [CNT_W-1:0] h_act_q, h_act_d, v_act_q, v_act_d;
   logic             locked_q, locked_d;

   always_comb begin
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      line_len_d = line_len_q;
      h_act_d    = h_act_q;
      v_act_d    = v_act_q;
      locked_d   = locked_q;
      if (de_q && (h_cnt_q != '1)) h_cnt_d = h_cnt_q + CNT_W'(1);
      if (de_prev_q && !de_q) begin
         line_len_d = h_cnt_q;
         h_cnt_d    = '0;
         if (v_cnt_q != '1) v_cnt_d = v_cnt_q + CNT_W'(1);
      end
      if (vs_edge) begin
         h_act_d  = line_len_q;
         v_act_d  = v_cnt_q;
         locked_d = (line_len_q == h_act_q) && (v_cnt_q == v_act_q) &&
                    (line_len_q != '0) && (v_cnt_q != '0);
         // A pixel coincident with the VS edge belongs to the new frame.
         h_cnt_d  = CNT_W'(de_q);
         v_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         de_prev_q  <= 1'b0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         line_len_q <= '0;
         h_act_q    <= '0;
         v_act_q    <= '0;
         locked_q   <= 1'b0;
      end else begin
         de_prev_q  <= de_q;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         line_len_q <= line_len_d;
         h_act_q    <= h_act_d;
         v_act_q    <= v_act_d;
         locked_q   <= locked_d;
      end
   end

   assign h_active_o = h_act_q;
   assign v_active_o = v_act_q;
   assign locked_o   = locked_q;
`else
   assign h_active_o = '0;
   assign v_active_o = '0;
   assign locked_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_dec.sv
`default_nettype none
// =============================================================================
// Module   : tb_video_dec
// Purpose  : Self-checking bench for video_dec against a line-level stream model.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
module tb_video_dec;
   localparam int BPP = 24;
   localparam int CW  = 12;
`ifdef VIDEO_DEC_MEASURE_EN
   localparam bit MEAS = 1'b1;
`else
   localparam bit MEAS = 1'b0;
`endif

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           de_i = 1'b0, vsync_i = 1'b0, out_axis_tready = 1'b0;
   logic [BPP-1:0] pixel_i = '0;
   logic           out_axis_tvalid, out_axis_tuser, out_axis_tlast, overflow_o, locked_o;
   logic [BPP-1:0] out_axis_tdata;
   logic [CW-1:0]  h_active_o, v_active_o;

   always #5 clk_i = ~clk_i;

   video_dec #(.BITS_PER_PIXEL(BPP), .FIFO_DEPTH(16), .CNT_W(CW)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .de_i(de_i), .vsync_i(vsync_i), .pixel_i(pixel_i),
      .out_axis_tvalid(out_axis_tvalid), .out_axis_tready(out_axis_tready),
      .out_axis_tdata(out_axis_tdata), .out_axis_tuser(out_axis_tuser),
      .out_axis_tlast(out_axis_tlast), .overflow_o(overflow_o),
      .h_active_o(h_active_o), .v_active_o(v_active_o), .locked_o(locked_o)
   );

   typedef struct packed {logic u; logic l; logic [BPP-1:0] d;} beat_t;

   beat_t exp_q[$], obs_q[$], dir_q[$];
   int    n_cmp = 0, n_bad = 0, matched = 0, cyc_n = 0, first_de = -1, first_v = -1;
   int    rdy_mode = 0;
   bit    sb_en = 1'b1, rst_req = 1'b1, hold_v = 1'b0;
   beat_t hold_b;

   // Line-level reference: a line's pixels are collected and emitted whole when
   // it ends (DE fall or VS edge); first pixel after a VS edge carries tuser.
   bit             m_vsp, m_act, m_sof, m_lsof;
   logic [BPP-1:0] m_line[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_vsp = 0; m_act = 0; m_sof = 0; m_lsof = 0;
      m_line.delete(); exp_q.delete(); obs_q.delete();
   endtask

   task automatic flush_line();
      for (int i = 0; i < m_line.size(); i++)
         exp_q.push_back({m_lsof && (i == 0), i == m_line.size() - 1, m_line[i]});
      m_line.delete();
   endtask

   task automatic model_feed(input logic de, input logic vs, input logic [BPP-1:0] pix);
      if (vs && !m_vsp) begin
         flush_line();
         m_act = 1; m_sof = 1;
      end
      m_vsp = vs;
      if (m_act && de) begin
         if (m_line.size() == 0) begin m_lsof = m_sof; m_sof = 0; end
         m_line.push_back(pix);
      end else if (m_line.size() != 0) begin
         flush_line();
      end
   endtask

   task automatic compare();
      beat_t o, e;
      while (obs_q.size() != 0 && exp_q.size() != 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check_eq("beat", 64'(o), 64'(e));
         matched++;
      end
   endtask

   task automatic cyc(input logic de, input logic vs, input logic [BPP-1:0] pix);
      beat_t b;
      logic  rdy;
      @(negedge clk_i);
      if (rst_i) begin
         check_eq("rst_tvalid", 64'(out_axis_tvalid), 64'd0);
         check_eq("rst_ovf", 64'(overflow_o), 64'd0);
         check_eq("rst_meas", {h_active_o, v_active_o, locked_o}, 64'd0);
         hold_v = 0;
      end
      rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(7) != 0) : 1'b0;
      out_axis_tready = rdy;
      b = {out_axis_tuser, out_axis_tlast, out_axis_tdata};
      if (hold_v && !rst_i) begin
         check_eq("hold_valid", 64'(out_axis_tvalid), 64'd1);
         check_eq("hold_beat", 64'(b), 64'(hold_b));
      end
      hold_v = out_axis_tvalid && !rdy;
      hold_b = b;
      if (out_axis_tvalid && first_v < 0) first_v = cyc_n;
      if (out_axis_tvalid && rdy) begin
         if (sb_en) obs_q.push_back(b);
         else       dir_q.push_back(b);
      end
      rst_i = rst_req;
      de_i = de; vsync_i = vs; pixel_i = pix;
      if (de && first_de < 0) first_de = cyc_n;
      if (rst_req) model_reset();
      else if (sb_en) model_feed(de, vs, pix);
      compare();
      cyc_n++;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, '0);
   endtask

   task automatic vs_lead();
      repeat (2) cyc(1'b0, 1'b1, '0);
      idle(2);
   endtask

   task automatic lines(input int w, input int h, input bit seq);
      for (int l = 0; l < h; l++) begin
         for (int i = 0; i < w; i++)
            cyc(1'b1, 1'b0, seq ? BPP'(l * w + i) : BPP'($urandom));
         idle(4);
      end
   endtask

   task automatic check_drained(input string tag);
      check_eq({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
      check_eq({tag, "_obs_left"}, 64'(obs_q.size()), 64'd0);
   endtask

   int base;

   initial begin
      model_reset();
      repeat (3) cyc(1'b0, 1'b0, '0);
      rst_req = 0;
      idle(2);

      // Steady 8x4 frame, latency and beat count
      rdy_mode = 0; first_de = -1; first_v = -1; base = matched;
      vs_lead();
      lines(8, 4, 0);
      check_eq("latency", 64'(first_v - first_de), 64'd3);

      // Lock sequence: frames 2 and 3 identical, then a 9x4 frame
      vs_lead();
      check_eq("steady_beats", 64'(matched - base), 64'd32);
      check_eq("h_after_f1", 64'(h_active_o), MEAS ? 64'd8 : 64'd0);
      check_eq("v_after_f1", 64'(v_active_o), MEAS ? 64'd4 : 64'd0);
      check_eq("lock_after_f1", 64'(locked_o), 64'd0);
      lines(8, 4, 0);
      vs_lead();
      check_eq("lock_after_f2", 64'(locked_o), MEAS ? 64'd1 : 64'd0);
      lines(8, 4, 0);
      vs_lead();
      check_eq("lock_after_f3", 64'(locked_o), MEAS ? 64'd1 : 64'd0);
      lines(9, 4, 0);
      vs_lead();
      check_eq("h_after_9", 64'(h_active_o), MEAS ? 64'd9 : 64'd0);
      check_eq("lock_after_9", 64'(locked_o), 64'd0);
      idle(8);
      check_drained("lock");

      // Back-pressure: 32-pixel line with tready low overflows a 16-deep FIFO
      sb_en = 0; rdy_mode = 2;
      vs_lead();
      lines(32, 1, 1);
      check_eq("ovf_set", 64'(overflow_o), 64'd1);
      dir_q.delete(); rdy_mode = 0;
      idle(24);
      check_eq("ovf_beats", 64'(dir_q.size()), 64'd16);
      for (int i = 0; i < dir_q.size(); i++) begin
         check_eq("ovf_data", 64'(dir_q[i].d), 64'(i));
         check_eq("ovf_user", 64'(dir_q[i].u), 64'(i == 0));
         check_eq("ovf_last", 64'(dir_q[i].l), 64'd0);
      end
      model_reset(); sb_en = 1;
      vs_lead();
      lines(8, 2, 0);
      idle(6);
      check_eq("ovf_sticky", 64'(overflow_o), 64'd1);
      check_drained("ovf");

      // Reset mid-frame with FIFO partly filled, release during active video
      rdy_mode = 2;
      vs_lead();
      repeat (8) cyc(1'b1, 1'b0, BPP'($urandom));
      rst_req = 1;
      repeat (3) cyc(1'b1, 1'b0, BPP'($urandom));
      rst_req = 0; rdy_mode = 1;
      repeat (4) cyc(1'b1, 1'b0, BPP'($urandom));
      idle(4);
      lines(8, 2, 0);
      vs_lead();
      lines(8, 3, 0);
      idle(10);
      check_drained("startup");

      // Truncated line: VS edge arrives with pixel 5 pending and DE still high
      rdy_mode = 0;
      vs_lead();
      lines(8, 1, 0);
      repeat (6) cyc(1'b1, 1'b0, BPP'($urandom));
      repeat (2) cyc(1'b1, 1'b1, BPP'($urandom));
      repeat (6) cyc(1'b1, 1'b0, BPP'($urandom));
      idle(4);
      lines(8, 2, 0);
      idle(10);
      check_drained("trunc");

      // Random frame sizes with random back-pressure
      rdy_mode = 1;
      repeat (6) begin
         vs_lead();
         lines($urandom_range(12, 1), $urandom_range(4, 1), 0);
      end
      rdy_mode = 0;
      idle(30);
      check_drained("random");
      check_eq("ovf_final", 64'(overflow_o), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
